// File: rtl/seq_divider.sv
// Radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// A request takes WIDTH DIV cycles plus one FIX cycle; done pulses in the
// cycle after FIX. Results hold until the next operation's FIX.
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;      // original dividend, returned as r on divide by zero
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quo;      // dividend magnitude shifts out MSB first, quotient shifts in
  logic [WIDTH-1:0] rem;
  logic             bz, ovf, neg_q, neg_r;

  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH:0]   rem_shift, sub;

  // Operand magnitudes at capture and the trial subtraction of one iteration.
  // The most-negative value negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1), so no magnitude is lost.
  always_comb begin
    mag_a_in  = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b_in  = (is_signed && b[WIDTH-1]) ? -b : b;
    rem_shift = {rem, quo[WIDTH-1]};
    // With rem < mag_b, rem_shift < 2*mag_b, so sub[WIDTH] is set exactly
    // when the trial subtraction goes negative (restore).
    sub       = rem_shift - {1'b0, mag_b};
  end

  assign busy = (state != IDLE);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      mag_b       <= '0;
      quo         <= '0;
      rem         <= '0;
      bz          <= 1'b0;
      ovf         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            mag_b <= mag_b_in;
            quo   <= mag_a_in;
            rem   <= '0;
            bz    <= (b == '0);
            ovf   <= is_signed && (a == MOST_NEG) && (b == '1);
            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed && a[WIDTH-1];
            cnt   <= CW'(WIDTH - 1);
            state <= DIV;
          end
        end
        DIV: begin
          rem <= sub[WIDTH] ? rem_shift[WIDTH-1:0] : sub[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~sub[WIDTH]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (bz) begin
            q           <= '1;
            r           <= a_q;
            div_by_zero <= 1'b1;
          end else if (ovf) begin
            q           <= a_q;
            r           <= '0;
            div_by_zero <= 1'b0;
          end else begin
            q           <= neg_q ? -quo : quo;
            r           <= neg_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          // start is deliberately not looked at here
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, random operands against an
// arithmetic reference, and hand-written busy-collision and reset-abort cases.
module tb_seq_divider;
  localparam int W = 64;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset, start, is_signed;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a, b, q, r;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  // Reference: plain language-level division with the two special cases
  // resolved first (SV signed / and % truncate toward zero, % follows dividend).
  task automatic model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] mq, output logic [W-1:0] mr, output logic mdz);
    mdz = 1'b0;
    if (bv == '0) begin
      mq = ONES; mr = av; mdz = 1'b1;
    end else if (s && av == MIN && bv == ONES) begin
      mq = av; mr = '0;
    end else if (s) begin
      mq = $signed(av) / $signed(bv);
      mr = $signed(av) % $signed(bv);
    end else begin
      mq = av / bv;
      mr = av % bv;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 50));
      2: return MIN;
      3: return ONES;
      4: return -64'($urandom_range(1, 50));
      5: return 64'd0;
      default: return {32'h0, $urandom};
    endcase
  endfunction

  // Issue one operation, scramble the inputs right after the start edge,
  // then check latency, output hold during DIV, result and the single pulse.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz);
    int k;
    logic [W-1:0] q0;
    logic held;
    @(negedge clk);
    start = 1'b1; is_signed = s; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    is_signed = 1'($urandom_range(0, 1));
    chk1({name, " busy"}, busy, 1'b1);
    q0 = q;
    held = 1'b1;
    for (k = 1; k <= W + 10; k++) begin
      @(posedge clk); #1;
      if (done) break;
      if (q !== q0) held = 1'b0;
    end
    chk({name, " latency"}, 64'(k), 64'(W + 1));
    chk1({name, " q held in DIV"}, held, 1'b1);
    chk({name, " q"}, q, eq);
    chk({name, " r"}, r, er);
    chk1({name, " dz"}, div_by_zero, edz);
    @(posedge clk); #1;
    chk1({name, " done 1 cycle"}, done, 1'b0);
    chk1({name, " idle"}, busy, 1'b0);
  endtask

  vec_t tbl[9];

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic rs, mdz;
    int k;

    tbl[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
    tbl[1] = '{1'b1, -64'd7, 64'd2, -64'd3, ONES, 1'b0};
    tbl[2] = '{1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1};
    tbl[3] = '{1'b1, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1};
    tbl[4] = '{1'b1, MIN, ONES, MIN, 64'd0, 1'b0};
    tbl[5] = '{1'b0, MIN, ONES, 64'd0, MIN, 1'b0};
    tbl[6] = '{1'b1, -64'd100, -64'd7, 64'd14, -64'd2, 1'b0};
    tbl[7] = '{1'b1, 64'd100, -64'd7, -64'd14, 64'd2, 1'b0};
    tbl[8] = '{1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk("reset q", q, '0);
    chk("reset r", r, '0);
    chk1("reset dz", div_by_zero, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    for (int i = 0; i < 30; i++) begin
      ra = pick(); rb = pick(); rs = 1'($urandom_range(0, 1));
      model(rs, ra, rb, mq, mr, mdz);
      run_op($sformatf("rnd%0d", i), rs, ra, rb, mq, mr, mdz);
    end

    // Second start in the middle of DIV and during DONE must be dropped.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 64'd1000; b = 64'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 64'd77; b = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 11; k <= W + 20; k++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    chk("collide latency", 64'(k), 64'(W + 1));
    chk("collide q", q, 64'd333);
    chk("collide r", r, 64'd1);
    @(negedge clk);
    start = 1'b1; a = 64'd9; b = 64'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("start in DONE ignored", busy, 1'b0);
    run_op("after collide", 1'b0, 64'd77, 64'd5, 64'd15, 64'd2, 1'b0);

    // Reset in the middle of DIV aborts silently; next start accepted at once.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 64'd12345; b = 64'd67;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    chk("abort q", q, '0);
    chk("abort r", r, '0);
    reset = 1'b0;
    run_op("post reset", 1'b0, ONES, 64'd1, ONES, 64'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
